// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: entry states, widths
// and the ROB-relative age compare.
package branch_resolve_unit_pkg;

  localparam int IDX_W = 6;
  localparam int PC_W  = 16;

  typedef enum logic [1:0] {
    ST_FREE = 2'b00,
    ST_PEND = 2'b01,
    ST_OK   = 2'b10
  } ent_st_e;

  typedef struct packed {
    ent_st_e          st;
    logic [IDX_W-1:0] indx;
  } brch_ent_t;

  // True when a is strictly younger than b, measured from the ROB head.
  function automatic logic age_younger(
    input logic [IDX_W-1:0] a,
    input logic [IDX_W-1:0] b,
    input logic [IDX_W-1:0] head
  );
    logic [IDX_W-1:0] age_a;
    logic [IDX_W-1:0] age_b;
    age_a = a - head;
    age_b = b - head;
    return age_a > age_b;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_alloc_pick.sv
// Priority picker: maps up to four dispatch slots onto the lowest
// free branch entries, slot 0 first.
module brch_alloc_pick #(
  parameter int NUM_BRCH = 4
) (
  input  logic [3:0]                dspt_req,
  input  logic [NUM_BRCH-1:0]       ent_free,
  output logic [NUM_BRCH-1:0]       ent_we,
  output logic [NUM_BRCH-1:0][1:0]  ent_sel
);

  logic [NUM_BRCH-1:0] avail;
  logic                taken;

  always_comb begin
    ent_we  = '0;
    ent_sel = '0;
    avail   = ent_free;
    taken   = 1'b0;
    for (int s = 0; s < 4; s++) begin
      taken = 1'b0;
      if (dspt_req[s]) begin
        for (int e = 0; e < NUM_BRCH; e++) begin
          if (!taken && avail[e]) begin
            ent_we[e]  = 1'b1;
            ent_sel[e] = 2'(s);
            avail[e]   = 1'b0;
            taken      = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch tracking table: resolve/commit/flush producer.
// Optional perf counters with BRU_PERF_CNT_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int NUM_BRCH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         alloc_vld,
  input  logic [4*IDX_W-1:0] alloc_indx,
  output logic               alloc_rdy,
  input  logic               rslv_vld,
  input  logic [IDX_W-1:0]   rslv_indx,
  input  logic               rslv_mis,
  input  logic [PC_W-1:0]    rslv_tgt,
  input  logic [IDX_W-1:0]   rob_head,
  input  logic               cmt_vld,
  input  logic [IDX_W-1:0]   cmt_indx,
  output logic               mis_pred,
  output logic [IDX_W-1:0]   brch_mis_indx,
  output logic [PC_W-1:0]    redirect_pc,
  output logic               cmt_brch,
  output logic [IDX_W-1:0]   cmt_brch_indx,
  output logic [3:0]         free_cnt
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [15:0]        perf_rslv,
  output logic [15:0]        perf_mis
`endif
);

  brch_ent_t [NUM_BRCH-1:0] ent_q, ent_d;

  logic                     mis_pred_q, mis_pred_d;
  logic [IDX_W-1:0]         brch_mis_indx_q, brch_mis_indx_d;
  logic [PC_W-1:0]          redirect_pc_q, redirect_pc_d;
  logic                     cmt_brch_q, cmt_brch_d;
  logic [IDX_W-1:0]         cmt_brch_indx_q, cmt_brch_indx_d;
  logic [3:0]               free_cnt_q, free_cnt_d;

  logic [NUM_BRCH-1:0]      ent_free;
  logic [NUM_BRCH-1:0]      ent_we;
  logic [NUM_BRCH-1:0][1:0] ent_sel;
  logic [2:0]               req_cnt;
  logic                     rslv_hit;
  logic                     mis_fire;
  logic                     cmt_hit;

  always_comb begin
    ent_free = '0;
    for (int e = 0; e < NUM_BRCH; e++)
      ent_free[e] = (ent_q[e].st == ST_FREE);
    req_cnt = {2'b0, alloc_vld[0]} + {2'b0, alloc_vld[1]}
            + {2'b0, alloc_vld[2]} + {2'b0, alloc_vld[3]};
  end

  assign alloc_rdy = ({1'b0, req_cnt} <= free_cnt_q);

  brch_alloc_pick #(
    .NUM_BRCH (NUM_BRCH)
  ) u_pick (
    .dspt_req (alloc_vld),
    .ent_free (ent_free),
    .ent_we   (ent_we),
    .ent_sel  (ent_sel)
  );

  always_comb begin
    ent_d    = ent_q;
    rslv_hit = 1'b0;
    cmt_hit  = 1'b0;
    for (int e = 0; e < NUM_BRCH; e++) begin
      if (rslv_vld && ent_q[e].st == ST_PEND &&
          ent_q[e].indx == rslv_indx)
        rslv_hit = 1'b1;
      if (cmt_vld && ent_q[e].st == ST_OK &&
          ent_q[e].indx == cmt_indx) begin
        cmt_hit     = 1'b1;
        ent_d[e].st = ST_FREE;
      end
    end
    mis_fire = rslv_hit && rslv_mis;

    for (int e = 0; e < NUM_BRCH; e++) begin
      if (rslv_hit && !rslv_mis && ent_q[e].st == ST_PEND &&
          ent_q[e].indx == rslv_indx)
        ent_d[e].st = ST_OK;
      // Squash the mispredicting branch and everything behind it.
      if (mis_fire && ent_q[e].st != ST_FREE &&
          (ent_q[e].indx == rslv_indx ||
           age_younger(ent_q[e].indx, rslv_indx, rob_head)))
        ent_d[e].st = ST_FREE;
    end

    if (alloc_rdy && !mis_fire) begin
      for (int e = 0; e < NUM_BRCH; e++) begin
        if (ent_we[e]) begin
          ent_d[e].st   = ST_PEND;
          ent_d[e].indx =
            alloc_indx[int'(ent_sel[e])*IDX_W +: IDX_W];
        end
      end
    end

    free_cnt_d = '0;
    for (int e = 0; e < NUM_BRCH; e++)
      free_cnt_d = free_cnt_d + {3'b0, ent_d[e].st == ST_FREE};

    mis_pred_d      = mis_fire;
    brch_mis_indx_d = mis_fire ? rslv_indx : brch_mis_indx_q;
    redirect_pc_d   = mis_fire ? rslv_tgt  : redirect_pc_q;
    cmt_brch_d      = cmt_hit;
    cmt_brch_indx_d = cmt_hit  ? cmt_indx  : cmt_brch_indx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q           <= '0;
      mis_pred_q      <= 1'b0;
      brch_mis_indx_q <= '0;
      redirect_pc_q   <= '0;
      cmt_brch_q      <= 1'b0;
      cmt_brch_indx_q <= '0;
      free_cnt_q      <= 4'(NUM_BRCH);
    end else begin
      ent_q           <= ent_d;
      mis_pred_q      <= mis_pred_d;
      brch_mis_indx_q <= brch_mis_indx_d;
      redirect_pc_q   <= redirect_pc_d;
      cmt_brch_q      <= cmt_brch_d;
      cmt_brch_indx_q <= cmt_brch_indx_d;
      free_cnt_q      <= free_cnt_d;
    end
  end

  assign mis_pred      = mis_pred_q;
  assign brch_mis_indx = brch_mis_indx_q;
  assign redirect_pc   = redirect_pc_q;
  assign cmt_brch      = cmt_brch_q;
  assign cmt_brch_indx = cmt_brch_indx_q;
  assign free_cnt      = free_cnt_q;

`ifdef BRU_PERF_CNT_EN
  logic [15:0] perf_rslv_q, perf_rslv_d;
  logic [15:0] perf_mis_q, perf_mis_d;

  always_comb begin
    perf_rslv_d = perf_rslv_q;
    perf_mis_d  = perf_mis_q;
    if (rslv_hit && perf_rslv_q != 16'hFFFF)
      perf_rslv_d = perf_rslv_q + 16'd1;
    if (mis_fire && perf_mis_q != 16'hFFFF)
      perf_mis_d = perf_mis_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rslv_q <= '0;
      perf_mis_q  <= '0;
    end else begin
      perf_rslv_q <= perf_rslv_d;
      perf_mis_q  <= perf_mis_d;
    end
  end

  assign perf_rslv = perf_rslv_q;
  assign perf_mis  = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit with an expected-result
// queue popped one cycle after each vector is driven.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alloc_vld;
  logic [23:0] alloc_indx;
  logic        alloc_rdy;
  logic        rslv_vld;
  logic [5:0]  rslv_indx;
  logic        rslv_mis;
  logic [15:0] rslv_tgt;
  logic [5:0]  rob_head;
  logic        cmt_vld;
  logic [5:0]  cmt_indx;
  logic        mis_pred;
  logic [5:0]  brch_mis_indx;
  logic [15:0] redirect_pc;
  logic        cmt_brch;
  logic [5:0]  cmt_brch_indx;
  logic [3:0]  free_cnt;
`ifdef BRU_PERF_CNT_EN
  logic [15:0] perf_rslv;
  logic [15:0] perf_mis;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.NUM_BRCH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_vld     (alloc_vld),
    .alloc_indx    (alloc_indx),
    .alloc_rdy     (alloc_rdy),
    .rslv_vld      (rslv_vld),
    .rslv_indx     (rslv_indx),
    .rslv_mis      (rslv_mis),
    .rslv_tgt      (rslv_tgt),
    .rob_head      (rob_head),
    .cmt_vld       (cmt_vld),
    .cmt_indx      (cmt_indx),
    .mis_pred      (mis_pred),
    .brch_mis_indx (brch_mis_indx),
    .redirect_pc   (redirect_pc),
    .cmt_brch      (cmt_brch),
    .cmt_brch_indx (cmt_brch_indx),
    .free_cnt      (free_cnt)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_rslv     (perf_rslv),
    .perf_mis      (perf_mis)
`endif
  );

  typedef struct {
    logic [3:0]  av;
    logic [23:0] ai;
    logic        rv;
    logic [5:0]  ri;
    logic        rm;
    logic [15:0] rt;
    logic [5:0]  hd;
    logic        cv;
    logic [5:0]  ci;
    logic        xr;
    logic        xm;
    logic [5:0]  xmi;
    logic [15:0] xpc;
    logic        xc;
    logic [5:0]  xci;
    logic [3:0]  xf;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [23:0] ai4(
    input logic [5:0] a0, input logic [5:0] a1,
    input logic [5:0] a2, input logic [5:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(
    input logic [3:0] av, input logic [23:0] ai,
    input logic rv, input logic [5:0] ri, input logic rm,
    input logic [15:0] rt, input logic [5:0] hd,
    input logic cv, input logic [5:0] ci,
    input logic xr, input logic xm, input logic [5:0] xmi,
    input logic [15:0] xpc, input logic xc,
    input logic [5:0] xci, input logic [3:0] xf);
    vec_t v;
    v.av = av; v.ai = ai; v.rv = rv; v.ri = ri; v.rm = rm;
    v.rt = rt; v.hd = hd; v.cv = cv; v.ci = ci; v.xr = xr;
    v.xm = xm; v.xmi = xmi; v.xpc = xpc; v.xc = xc;
    v.xci = xci; v.xf = xf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    alloc_vld = '0; alloc_indx = '0;
    rslv_vld = 1'b0; rslv_indx = '0; rslv_mis = 1'b0;
    rslv_tgt = '0; cmt_vld = 1'b0; cmt_indx = '0;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    alloc_vld = v.av; alloc_indx = v.ai;
    rslv_vld = v.rv; rslv_indx = v.ri; rslv_mis = v.rm;
    rslv_tgt = v.rt; rob_head = v.hd;
    cmt_vld = v.cv; cmt_indx = v.ci;
    #1;
    n_vec++;
    chk($sformatf("alloc_rdy[%0d]", n_vec), 32'(alloc_rdy),
        32'(v.xr));
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("mis_pred[%0d]", n_vec), 32'(mis_pred),
        32'(e.xm));
    if (e.xm) begin
      chk($sformatf("mis_indx[%0d]", n_vec),
          32'(brch_mis_indx), 32'(e.xmi));
      chk($sformatf("redirect[%0d]", n_vec),
          32'(redirect_pc), 32'(e.xpc));
    end
    chk($sformatf("cmt_brch[%0d]", n_vec), 32'(cmt_brch),
        32'(e.xc));
    if (e.xc)
      chk($sformatf("cmt_indx[%0d]", n_vec),
          32'(cmt_brch_indx), 32'(e.xci));
    chk($sformatf("free_cnt[%0d]", n_vec), 32'(free_cnt),
        32'(e.xf));
  endtask

  initial begin
    logic [23:0] z;
    z = '0;
    // alloc 5,6; resolve/commit 5; commit PEND 6 is ignored
    vt.push_back(mk(4'b0011, ai4(5,6,0,0), 0,0,0,0, 0, 0,0,
                    1, 0,0,0, 0,0, 2));
    vt.push_back(mk(0, z, 1,5,0,0, 0, 0,0, 1, 0,0,0, 0,0, 2));
    vt.push_back(mk(0, z, 0,0,0,0, 0, 1,5, 1, 0,0,0, 1,5, 3));
    vt.push_back(mk(0, z, 0,0,0,0, 0, 1,6, 1, 0,0,0, 0,0, 3));
    vt.push_back(mk(0, z, 1,6,0,0, 0, 0,0, 1, 0,0,0, 0,0, 3));
    vt.push_back(mk(0, z, 0,0,0,0, 0, 1,6, 1, 0,0,0, 1,6, 4));
    // head 8: 10,11,12; mispredict 11 squashes 12
    vt.push_back(mk(4'b0111, ai4(10,11,12,0), 0,0,0,0, 8, 0,0,
                    1, 0,0,0, 0,0, 1));
    vt.push_back(mk(0, z, 1,11,1,16'h0400, 8, 0,0,
                    1, 1,11,16'h0400, 0,0, 3));
    vt.push_back(mk(0, z, 1,12,1,16'h0999, 8, 0,0,
                    1, 0,0,0, 0,0, 3));
    vt.push_back(mk(0, z, 1,10,0,0, 8, 0,0, 1, 0,0,0, 0,0, 3));
    vt.push_back(mk(0, z, 0,0,0,0, 8, 1,10, 1, 0,0,0, 1,10, 4));
    // wrap: head 62, 63 older than 1
    vt.push_back(mk(4'b0011, ai4(63,1,0,0), 0,0,0,0, 62, 0,0,
                    1, 0,0,0, 0,0, 2));
    vt.push_back(mk(0, z, 1,63,1,16'h1234, 62, 0,0,
                    1, 1,63,16'h1234, 0,0, 4));
    vt.push_back(mk(0, z, 1,1,1,16'h1111, 62, 0,0,
                    1, 0,0,0, 0,0, 4));
    // younger then older mispredict, back to back
    vt.push_back(mk(4'b0111, ai4(20,21,22,0), 0,0,0,0, 20, 0,0,
                    1, 0,0,0, 0,0, 1));
    vt.push_back(mk(0, z, 1,22,1,16'h0222, 20, 0,0,
                    1, 1,22,16'h0222, 0,0, 2));
    vt.push_back(mk(0, z, 1,20,1,16'h0200, 20, 0,0,
                    1, 1,20,16'h0200, 0,0, 4));
    // full table, refused alloc, alloc dropped by flush
    vt.push_back(mk(4'b1111, ai4(30,31,32,33), 0,0,0,0, 30, 0,0,
                    1, 0,0,0, 0,0, 0));
    vt.push_back(mk(4'b0001, ai4(40,0,0,0), 0,0,0,0, 30, 0,0,
                    0, 0,0,0, 0,0, 0));
    vt.push_back(mk(0, z, 1,33,1,16'h0330, 30, 0,0,
                    1, 1,33,16'h0330, 0,0, 1));
    vt.push_back(mk(4'b0001, ai4(50,0,0,0), 1,31,1,16'h0310, 30,
                    0,0, 1, 1,31,16'h0310, 0,0, 3));
    vt.push_back(mk(0, z, 1,50,1,16'h0500, 30, 0,0,
                    1, 0,0,0, 0,0, 3));
    vt.push_back(mk(0, z, 1,30,0,0, 30, 0,0, 1, 0,0,0, 0,0, 3));
    vt.push_back(mk(0, z, 0,0,0,0, 30, 1,30, 1, 0,0,0, 1,30, 4));
    // resolve and commit in the same cycle
    vt.push_back(mk(4'b0011, ai4(2,3,0,0), 0,0,0,0, 2, 0,0,
                    1, 0,0,0, 0,0, 2));
    vt.push_back(mk(0, z, 1,2,0,0, 2, 0,0, 1, 0,0,0, 0,0, 2));
    vt.push_back(mk(0, z, 1,3,1,16'h0033, 2, 1,2,
                    1, 1,3,16'h0033, 1,2, 4));
    // unknown index
    vt.push_back(mk(0, z, 1,9,1,16'h0009, 2, 0,0,
                    1, 0,0,0, 0,0, 4));
    vt.push_back(mk(4'b0001, ai4(7,0,0,0), 0,0,0,0, 0, 0,0,
                    1, 0,0,0, 0,0, 3));

    rob_head = '0;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    chk("rst_mis_pred", 32'(mis_pred), 0);
    chk("rst_cmt_brch", 32'(cmt_brch), 0);
    chk("rst_mis_indx", 32'(brch_mis_indx), 0);
    chk("rst_redirect", 32'(redirect_pc), 0);
    chk("rst_free_cnt", 32'(free_cnt), 4);
    chk("rst_alloc_rdy", 32'(alloc_rdy), 1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) apply(vt[i]);

    // reset lands on the same edge as a mispredict of entry 7
    @(negedge clk);
    rst = 1'b1;
    rslv_vld = 1'b1; rslv_indx = 6'd7; rslv_mis = 1'b1;
    rslv_tgt = 16'h7777;
    @(posedge clk);
    #1;
    n_vec++;
    chk("midrst_mis_pred", 32'(mis_pred), 0);
    chk("midrst_free_cnt", 32'(free_cnt), 4);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    chk("midrst_no_pulse", 32'(mis_pred), 0);
    apply(mk(0, z, 1,7,1,16'h7777, 0, 0,0, 1, 0,0,0, 0,0, 4));

    @(negedge clk);
    drive_idle();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
